io_clock_enables: RTL
=====================

IO_CLOCK_ENABLES -- requirements
Module: io_clock_enables

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of clock-enable channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each channel's divide value and counter.
REQ-003 The block SHALL have parameter RST_HOLD_CYCLES, default 16, meaning the cycles reset_out stays high after synchronised lock (1..2^16-1).
REQ-004 The block SHALL have parameter DEFAULT_DIV, default 3, meaning the per-channel divide value loaded at reset.
REQ-005 clk  input  1  sole clock; all logic on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 locked  input  1  asynchronous MMCM lock indication.
REQ-008 div_val  input  NUM_CH*CNT_W  packed divide values; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 div_load  input  1  one-cycle strobe capturing div_val into the shadow registers.
REQ-010 reset_out  output  1  active-high system reset for downstream logic.
REQ-011 ce  output  NUM_CH  per-channel clock-enable strobes.
REQ-012 lock_loss_cnt  output  8  count of lock losses seen in RUN.

Function
REQ-013 locked SHALL pass through a 2-flop synchroniser (locked_s); all decisions use locked_s.
REQ-014 The FSM SHALL have states HOLD, COUNT and RUN.
REQ-015 HOLD -> COUNT when locked_s=1; the hold counter clears to 0.
REQ-016 COUNT: the hold counter increments each cycle; COUNT -> RUN on the cycle the counter equals RST_HOLD_CYCLES-1; COUNT -> HOLD if locked_s=0.
REQ-017 RUN -> HOLD when locked_s=0, in the same cycle locked_s is sampled low.
REQ-018 reset_out SHALL be registered: 1 in HOLD and COUNT, 0 in RUN; it falls exactly RST_HOLD_CYCLES+1 cycles after locked_s rises, provided lock holds throughout.
REQ-019 Each channel SHALL have a CNT_W-bit counter and an active divide register div_act[i] with a divide value N.
REQ-020 N>=2: the counter counts 0..N-1 and wraps to 0; ce[i]=1 for exactly the one cycle in which the counter equals N-1, giving one pulse per N cycles.
REQ-021 N=0 or N=1: ce[i] SHALL be 1 every cycle while in RUN.
REQ-022 Outside RUN, counters SHALL be held at 0 and ce SHALL be all 0.
REQ-023 With N>=2, the first ce[i] pulse SHALL occur in the Nth cycle in which reset_out=0.
REQ-024 div_load=1 SHALL capture div_val into the shadow registers and set a per-channel pending flag.
REQ-025 A pending shadow value SHALL transfer to div_act[i] only at that channel's wrap (counter = N-1, or any cycle if N<=1), then the counter restarts at 0 and pending clears, so no shortened or lengthened period occurs.
REQ-026 When div_load repeats before a transfer, the latest value wins.
REQ-027 Outside RUN, a pending value SHALL transfer immediately.
REQ-028 ce SHALL be combinationally decoded from registered state only; it SHALL NOT depend combinationally on any input.

Reset
REQ-029 With rst=1 the block SHALL go to state HOLD with reset_out=1, ce=0, all counters 0, div_act and shadow = DEFAULT_DIV, pending=0, synchroniser=0 and lock_loss_cnt=0.
REQ-030 rst asserted mid-RUN SHALL force these values on the next clock edge, regardless of locked.

Configuration
REQ-031 Macro IO_CLOCKS_LOCK_LOSS_CNT_EN: when defined, lock_loss_cnt SHALL increment by 1 on each RUN -> HOLD transition and saturate at 255.
REQ-032 Without IO_CLOCKS_LOCK_LOSS_CNT_EN, lock_loss_cnt SHALL be constant 0 and no counter logic is synthesised; all other behaviour is identical.

Verification
REQ-033 Defaults, locked rises at cycle 10 -> reset_out falls at cycle 10+2+16+1 = 29 ±0; ce[0] first pulses 3 cycles later, then every 3 cycles.
REQ-034 In RUN, drop locked for 5 cycles -> reset_out=1 and ce=0 two cycles after the drop; full 16-cycle hold on relock; lock_loss_cnt=1 (macro on) or 0 (macro off).
REQ-035 In RUN with channel 1 at N=3, load div_val=5 mid-period -> the current 3-cycle period completes, then pulses every 5 cycles; no gap is ever <3 or >5.
REQ-036 Load N=1 on channel 0 -> ce[0] stays high every RUN cycle; load N=0 -> same result.
REQ-037 Assert rst for 1 cycle mid-RUN with locked=1 -> the next cycle shows reset_out=1, ce=0 and div_act=3; RUN is re-entered after the hold sequence.
REQ-038 Macro on: 300 lock-loss cycles -> lock_loss_cnt saturates at 255.

Source files
------------

// File: rtl/io_clock_enables.sv
// rtl/io_clock_enables.sv - lock-qualified reset release and per-channel clock-enable dividers
// Optional lock-loss counter enabled by defining IO_CLOCKS_LOCK_LOSS_CNT_EN.
module io_clock_enables #(
  parameter int NUM_CH          = 2,
  parameter int CNT_W           = 16,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DEFAULT_DIV     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic                    div_load,
  output logic                    reset_out,
  output logic [NUM_CH-1:0]       ce,
  output logic [7:0]              lock_loss_cnt
);

  typedef enum logic [1:0] {HOLD, COUNT, RUN} state_t;

  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEFAULT_DIV);
  localparam logic [15:0]      HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);

  state_t      state;
  logic        sync1;
  logic        locked_s;
  logic [15:0] hold_cnt;
  logic        run_stay;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  // RUN is left on the very edge at which locked_s captures the low level
  assign run_stay = (state == RUN) && sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= 16'd0;
      reset_out <= 1'b1;
    end else begin
      case (state)
        HOLD: begin
          reset_out <= 1'b1;
          hold_cnt  <= 16'd0;
          if (locked_s) state <= COUNT;
        end
        COUNT: begin
          if (!locked_s) begin
            state    <= HOLD;
            hold_cnt <= 16'd0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            reset_out <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!sync1) begin
            state     <= HOLD;
            reset_out <= 1'b1;
          end
        end
        default: begin
          state     <= HOLD;
          reset_out <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shadow;
    logic             pending;
    logic             wrap;

    // N of 0 or 1 means every cycle is a wrap
    assign wrap  = (div_act <= CNT_W'(1)) || (cnt == div_act - CNT_W'(1));
    assign ce[i] = (state == RUN) && wrap;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt        <= '0;
        div_act    <= DIV_RST;
        div_shadow <= DIV_RST;
        pending    <= 1'b0;
      end else begin
        if (!run_stay || wrap) cnt <= '0;
        else                   cnt <= cnt + CNT_W'(1);

        if (div_load) begin
          div_shadow <= div_val[i*CNT_W +: CNT_W];
          pending    <= 1'b1;
        end else if (pending && ((state != RUN) || wrap)) begin
          div_act <= div_shadow;
          pending <= 1'b0;
        end
      end
    end
  end

`ifdef IO_CLOCKS_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk) begin
    if (rst) loss_q <= 8'd0;
    else if ((state == RUN) && !sync1 && (loss_q != 8'hFF)) loss_q <= loss_q + 8'd1;
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
